fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
Downstream consumer of the 16x8 byte FIFO. It pops bytes through the FIFO read port (re/empty/data_out) and serializes each one as an 8N1 UART frame on a single tx line, LSB first. It sits between the FIFO and the board-level serial pin, and is the drain stage for all buffered bytes.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit period; legal values are 2 or more.
STOP_BITS, 1, number of stop bits; legal values are 1 or 2.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
tx_en  input  1  enables the start of new frames; a frame already in progress always completes.
fifo_empty  input  1  FIFO empty flag.
fifo_data  input  8  FIFO data_out; registered, valid the cycle after fifo_re.
fifo_re  output  1  FIFO read strobe; one-cycle pulse per byte.
tx  output  1  serial output; idles high.
busy  output  1  high from the POP state through the end of the last stop bit.
tx_done  output  1  one-cycle pulse in the final cycle of the last stop bit.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, tx=1, fifo_re=0, busy=0, tx_done=0.
  - Baud counter, bit index and shift register are cleared.
  - Reset asserted mid-frame aborts the frame immediately; tx goes high with no partial stop bit.
- All outputs are registered.
- FSM states: IDLE, POP, LOAD, START, DATA, [PARITY], STOP.
- IDLE:
  - tx=1.
  - If tx_en && !fifo_empty, go to POP; otherwise stay in IDLE.
- POP (1 cycle):
  - fifo_re=1 for exactly this cycle; busy=1.
  - Go to LOAD.
- LOAD (1 cycle):
  - Capture fifo_data into the 8-bit shift register. This accounts for the FIFO's one-cycle read latency; fifo_data is not sampled in any other cycle, because the FIFO zeroes data_out when not reading.
  - Go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - tx=shift[0] for CLKS_PER_BIT cycles; then shift right and increment the bit index.
  - After bit index 7 completes, go to PARITY if it is compiled in, else STOP.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - tx_done pulses in the last cycle.
  - Next state: POP if tx_en && !fifo_empty (back-to-back frames), else IDLE.
- Baud counter:
  - Width is $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary; it is reset to 0 on entry to START.
- Frame timing: frame length is (10+STOP_BITS-1)*CLKS_PER_BIT cycles without parity. The gap between frames is exactly 2 idle-high cycles (POP and LOAD).
- fifo_re is never asserted while fifo_empty=1, nor in two consecutive cycles.
- tx_en may change at any time. Deasserting it mid-frame has no effect until the frame ends; the FSM then returns to IDLE.
- Bytes are consumed in FIFO order. No byte is dropped or duplicated.

Optional Feature:
Macro: FIFO_UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame length grows by one bit period.
- Undefined: the PARITY state and its XOR logic are absent, and the frame is plain 8N1 (or 8N2).

Test Plan:
1. CLKS_PER_BIT=4, STOP_BITS=1, reset released; preload FIFO with 0xA5, tx_en=1:
   - One fifo_re pulse.
   - tx sequence in 4-cycle bits: 0, 1,0,1,0,0,1,0,1, 1.
   - busy high for 42 cycles; tx_done pulses once.
2. FIFO holding 0x01, 0x02, 0x03, tx_en=1:
   - Three frames in order.
   - Exactly 2 high cycles between each stop bit and the next start bit.
   - After the third frame, FSM returns to IDLE with fifo_re=0.
3. FIFO empty, tx_en=1, run for 100 cycles:
   - fifo_re never asserts, tx=1, busy=0.
4. Byte 0x3C, tx_en deasserted at the 3rd data bit:
   - Frame completes intact.
   - A second queued byte is not popped until tx_en=1 again.
5. reset driven low in the middle of data bit 4:
   - Same cycle: tx=1, busy=0.
   - After release: IDLE; the next queued byte is sent as a fresh, complete frame.
6. With FIFO_UART_TX_PARITY_EN defined and CLKS_PER_BIT=4:
   - 0xA5 gives parity bit 0; 0x07 gives parity bit 1.
   - Each frame is 44 cycles of serial time.

Source files
------------

// File: rtl/fifo_uart_tx_if.sv
// Read port between the 16x8 byte FIFO and its UART drain stage.
// The consumer (master) issues fifo_re; the FIFO (slave) answers with empty flag and registered data.
interface fifo_uart_tx_if;
  logic       fifo_re;
  logic       fifo_empty;
  logic [7:0] fifo_data;

  modport master (
    output fifo_re,
    input  fifo_empty,
    input  fifo_data
  );

  modport slave (
    input  fifo_re,
    output fifo_empty,
    output fifo_data
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains the byte FIFO and serializes each byte as an LSB-first UART frame; FIFO_UART_TX_PARITY_EN adds an even-parity bit.
// Latency: 2 cycles (POP, LOAD) from pop decision to start bit; frame = (10+STOP_BITS-1[+1])*CLKS_PER_BIT cycles.
// Backpressure: pops only when tx_en && !fifo_empty at frame boundaries; a started frame always completes.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tx_en,
  fifo_uart_tx_if.master rd,
  output logic           tx,
  output logic           busy,
  output logic           tx_done
);

  localparam int              CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   BAUD_PRE  = CW'(CLKS_PER_BIT - 2);
  localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_q;
  logic          fifo_re_q;
`ifdef FIFO_UART_TX_PARITY_EN
  logic          parity_q;
`endif

  assign rd.fifo_re = fifo_re_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_q   <= '0;
      fifo_re_q <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      fifo_re_q <= 1'b0;
      tx_done   <= 1'b0;
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (tx_en && !rd.fifo_empty) begin
            state     <= POP;
            fifo_re_q <= 1'b1;
            busy      <= 1'b1;
          end
        end
        POP: state <= LOAD;
        // FIFO data_out is only valid in the cycle after the read strobe.
        LOAD: begin
          shift_q  <= rd.fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
          parity_q <= ^rd.fifo_data;
`endif
          baud_cnt <= '0;
          tx       <= 1'b0;
          state    <= START;
        end
        START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shift_q[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            shift_q  <= shift_q >> 1;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
              tx      <= parity_q;
              state   <= PARITY;
`else
              tx      <= 1'b1;
              state   <= STOP;
`endif
            end else begin
              tx      <= shift_q[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          // Registered pulse: raised one cycle early so it lands on the final stop cycle.
          if (bit_idx == STOP_LAST && baud_cnt == BAUD_PRE)
            tx_done <= 1'b1;
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == STOP_LAST) begin
              bit_idx <= '0;
              if (tx_en && !rd.fifo_empty) begin
                state     <= POP;
                fifo_re_q <= 1'b1;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at CLKS_PER_BIT=4, STOP_BITS=1 with a behavioural 16-deep FIFO.
// Builds with or without FIFO_UART_TX_PARITY_EN; frame vectors are {stop,[parity],data,start}, index 0 first.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam logic [10:0] F_A5 = {2'b10, 8'hA5, 1'b0};
  localparam logic [10:0] F_01 = {2'b11, 8'h01, 1'b0};
  localparam logic [10:0] F_02 = {2'b11, 8'h02, 1'b0};
  localparam logic [10:0] F_03 = {2'b10, 8'h03, 1'b0};
  localparam logic [10:0] F_3C = {2'b10, 8'h3C, 1'b0};
  localparam logic [10:0] F_5A = {2'b10, 8'h5A, 1'b0};
  localparam logic [10:0] F_0F = {2'b10, 8'h0F, 1'b0};
  localparam logic [10:0] F_07 = {2'b11, 8'h07, 1'b0};
`else
  localparam int NB = 10;
  localparam logic [10:0] F_A5 = {2'b01, 8'hA5, 1'b0};
  localparam logic [10:0] F_01 = {2'b01, 8'h01, 1'b0};
  localparam logic [10:0] F_02 = {2'b01, 8'h02, 1'b0};
  localparam logic [10:0] F_03 = {2'b01, 8'h03, 1'b0};
  localparam logic [10:0] F_3C = {2'b01, 8'h3C, 1'b0};
  localparam logic [10:0] F_5A = {2'b01, 8'h5A, 1'b0};
  localparam logic [10:0] F_0F = {2'b01, 8'h0F, 1'b0};
  localparam logic [10:0] F_07 = {2'b01, 8'h07, 1'b0};
`endif
  localparam int BUSY_CYC = 2 + NB * CPB;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tx_en = 1'b0;
  logic tx, busy, tx_done;

  fifo_uart_tx_if rd ();

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_en   (tx_en),
    .rd      (rd),
    .tx      (tx),
    .busy    (busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: registered data_out, zero when not reading.
  logic [7:0] mem [0:15];
  logic [4:0] wr_p = '0;
  logic [4:0] rd_p = '0;
  int         pop_cnt = 0;
  logic       push_req = 1'b0;
  logic [7:0] push_byte = '0;
  logic       prev_re = 1'b0;
  logic       bad_re_empty = 1'b0;
  logic       bad_re_back = 1'b0;

  assign rd.fifo_empty = (wr_p == rd_p);

  always @(posedge clk) begin
    if (push_req) begin
      mem[wr_p[3:0]] <= push_byte;
      wr_p <= wr_p + 1'b1;
    end
    if (rd.fifo_re && wr_p == rd_p) bad_re_empty <= 1'b1;
    if (rd.fifo_re && prev_re) bad_re_back <= 1'b1;
    prev_re <= rd.fifo_re;
    if (rd.fifo_re && wr_p != rd_p) begin
      rd.fifo_data <= mem[rd_p[3:0]];
      rd_p <= rd_p + 1'b1;
      pop_cnt <= pop_cnt + 1;
    end else begin
      rd.fifo_data <= 8'h00;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    push_byte = b;
    push_req = 1'b1;
    @(posedge clk);
    #1 push_req = 1'b0;
  endtask

  // Waits for the pop, then checks gap cycles, every bit period, tx_done placement and busy length.
  // drop_bit >= 0 deasserts tx_en at the start of that frame bit.
  task automatic run_frame(input string tag, input logic [10:0] exp_bits, input int drop_bit,
                           output int waited);
    int         busy_n;
    logic [3:0] s, d;
    logic       stray_done, stray_re, found;
    waited = 0;
    found = 1'b0;
    while (!found && waited < 300) begin
      @(negedge clk);
      if (rd.fifo_re) found = 1'b1;
      else waited++;
    end
    check({tag, " pop seen"}, 32'(found), 32'd1);
    if (!found) return;
    check({tag, " pop tx"}, 32'(tx), 32'd1);
    busy_n = int'(busy);
    @(negedge clk);
    check({tag, " load re"}, 32'(rd.fifo_re), 32'd0);
    check({tag, " load tx"}, 32'(tx), 32'd1);
    busy_n += int'(busy);
    stray_done = 1'b0;
    stray_re = 1'b0;
    for (int b = 0; b < NB; b++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        s[c] = tx;
        d[c] = tx_done;
        busy_n += int'(busy);
        if (rd.fifo_re) stray_re = 1'b1;
        if (b == drop_bit && c == 0) tx_en = 1'b0;
      end
      check($sformatf("%s bit%0d", tag, b), 32'(s), {28'd0, {4{exp_bits[b]}}});
      if (b == NB - 1) check({tag, " done pos"}, 32'(d), 32'h8);
      else stray_done |= |d;
    end
    check({tag, " early done"}, 32'(stray_done), 32'd0);
    check({tag, " re in frame"}, 32'(stray_re), 32'd0);
    check({tag, " busy len"}, 32'(busy_n), 32'(BUSY_CYC));
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int   w;
    int   pc;
    logic any_re, any_busy, any_low;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst tx", 32'(tx), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst re", 32'(rd.fifo_re), 32'd0);
    check("rst done", 32'(tx_done), 32'd0);
    reset = 1'b1;

    // 1: single byte 0xA5
    push(8'hA5);
    tx_en = 1'b1;
    run_frame("t1", F_A5, -1, w);
    @(negedge clk);
    check("t1 idle busy", 32'(busy), 32'd0);
    check("t1 idle tx", 32'(tx), 32'd1);
    check("t1 pops", 32'(pop_cnt), 32'd1);

    // 2: three queued bytes back-to-back
    tx_en = 1'b0;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    tx_en = 1'b1;
    run_frame("t2a", F_01, -1, w);
    run_frame("t2b", F_02, -1, w);
    check("t2b gap", 32'(w), 32'd0);
    run_frame("t2c", F_03, -1, w);
    check("t2c gap", 32'(w), 32'd0);
    @(negedge clk);
    check("t2 end re", 32'(rd.fifo_re), 32'd0);
    check("t2 end busy", 32'(busy), 32'd0);
    check("t2 pops", 32'(pop_cnt), 32'd4);

    // 3: empty FIFO, enabled, 100 cycles
    any_re = 1'b0; any_busy = 1'b0; any_low = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      any_re |= rd.fifo_re;
      any_busy |= busy;
      any_low |= ~tx;
    end
    check("t3 re", 32'(any_re), 32'd0);
    check("t3 busy", 32'(any_busy), 32'd0);
    check("t3 tx low", 32'(any_low), 32'd0);

    // 4: tx_en dropped at data bit 2; second byte held until re-enabled
    tx_en = 1'b0;
    push(8'h3C);
    push(8'h5A);
    tx_en = 1'b1;
    run_frame("t4a", F_3C, 3, w);
    pc = pop_cnt;
    repeat (20) @(negedge clk);
    check("t4 held pops", 32'(pop_cnt), 32'(pc));
    check("t4 held busy", 32'(busy), 32'd0);
    tx_en = 1'b1;
    run_frame("t4b", F_5A, -1, w);
    check("t4 pops", 32'(pop_cnt), 32'd6);

    // 5: reset in the middle of data bit 4 of 0x86, then 0x0F sent fresh
    tx_en = 1'b0;
    push(8'h86);
    push(8'h0F);
    tx_en = 1'b1;
    w = 0;
    while (!rd.fifo_re && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("t5 pop seen", 32'(rd.fifo_re), 32'd1);
    repeat (24) @(negedge clk);
    check("t5 mid bit4 tx", 32'(tx), 32'd0);
    check("t5 mid busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("t5 rst tx", 32'(tx), 32'd1);
    check("t5 rst busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    check("t5 rst re", 32'(rd.fifo_re), 32'd0);
    reset = 1'b1;
    run_frame("t5b", F_0F, -1, w);
    check("t5 pops", 32'(pop_cnt), 32'd8);

    // 6: 0x07 (odd parity weight)
    tx_en = 1'b0;
    push(8'h07);
    tx_en = 1'b1;
    run_frame("t6", F_07, -1, w);
    @(negedge clk);
    check("t6 pops", 32'(pop_cnt), 32'd9);
    check("t6 idle busy", 32'(busy), 32'd0);
    check("re while empty", 32'(bad_re_empty), 32'd0);
    check("re consecutive", 32'(bad_re_back), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
